// File: rtl/cbi980_pkg.sv
// Shared definitions for the cbi980 I2S transmitter.
//   tx_state_t : transmitter FSM state encoding
//   SLOT_16/32 : slot lengths in bit clocks
//   slot_last  : index of the LSB bit for the selected slot size
package cbi980_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } tx_state_t;

    localparam int unsigned SLOT_16   = 16;
    localparam int unsigned SLOT_32   = 32;
    localparam int unsigned BIT_IDX_W = 5;

    function automatic logic [BIT_IDX_W-1:0] slot_last(input logic wlen);
        return wlen ? BIT_IDX_W'(SLOT_32 - 1) : BIT_IDX_W'(SLOT_16 - 1);
    endfunction

endpackage

// File: rtl/cbi980_fifo.sv
// Single-clock synchronous FIFO holding outgoing audio samples.
//   clk, rst : clock, asynchronous active-high reset (empties the FIFO)
//   push     : write request, refused while full
//   wdata    : write data
//   full     : FIFO full (evaluated before any same-cycle pop)
//   pop      : read request, ignored while empty
//   empty    : FIFO empty (evaluated before any same-cycle push)
//   rdata    : head word, valid while not empty
//   level    : occupancy in words
module cbi980_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    output logic                     full,
    input  logic                     pop,
    output logic                     empty,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/cbi980_i2s_tx.sv
// I2S transmitter: sample FIFO, BCLK divider, left/right slot sequencer and
// MSB-first shifter.
//   clk, rst      : clock, asynchronous active-high reset
//   en            : transmit enable (stop is deferred to the end of a frame)
//   clkdiv        : BCLK half-period in clk cycles minus 1 (latched at start)
//   wlen          : 0 = 16-bit slot, 1 = 32-bit slot (latched at start)
//   s_data/s_valid/s_ready : MSB-justified sample input handshake
//   level         : FIFO occupancy
//   underrun      : sticky, set by a pop from an empty FIFO
//   underrun_clr  : clears underrun (a same-cycle set wins)
//   irq           : underrun or FIFO at most half full while enabled
//   bclk, lrclk, sdata : I2S serial outputs
module cbi980_i2s_tx
    import cbi980_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned DIV_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [DIV_W-1:0]         clkdiv,
    input  logic                     wlen,
    input  logic [31:0]              s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     underrun,
    input  logic                     underrun_clr,
    output logic                     irq,
    output logic                     bclk,
    output logic                     lrclk,
    output logic                     sdata
);

    localparam int unsigned LW = $clog2(DEPTH) + 1;

    tx_state_t              state;
    tx_state_t              state_nxt;
    logic [DIV_W-1:0]       div_lat;
    logic [DIV_W-1:0]       div_cnt;
    logic                   wlen_lat;
    logic                   first;
    logic [BIT_IDX_W-1:0]   bit_k;
    logic [BIT_IDX_W-1:0]   k_last;
    logic [BIT_IDX_W-1:0]   k_inc;
    logic [31:0]            shreg;
    logic [31:0]            nxt_word;
    logic                   ready_en;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [31:0]            fifo_rdata;
    logic [31:0]            pop_word;
    logic                   div_tc;
    logic                   ev;
    logic                   at_lsb;
    logic                   stop;
    logic                   do_pop;

    // ready_en is 0 only during reset and releases on the first edge after it.
    assign s_ready = ready_en & ~fifo_full;
    // ready_en also masks the level term so irq stays low while in reset.
    assign irq     = underrun | (en & ready_en & (level <= LW'(DEPTH / 2)));

    cbi980_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s_valid & s_ready),
        .wdata (s_data),
        .full  (fifo_full),
        .pop   (do_pop),
        .empty (fifo_empty),
        .rdata (fifo_rdata),
        .level (level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ev marks a BCLK falling-edge event: the cycle bclk goes 1->0, plus the
    // first RUN cycle. at_lsb is the event that drives a slot's LSB.
    always_comb begin
        state_nxt = state;
        div_tc    = (div_cnt == div_lat);
        k_last    = slot_last(wlen_lat);
        k_inc     = bit_k + 1'b1;
        ev        = 1'b0;
        at_lsb    = 1'b0;
        stop      = 1'b0;
        do_pop    = 1'b0;
        pop_word  = fifo_empty ? '0 : fifo_rdata;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                ev     = first | (bclk & div_tc);
                at_lsb = ev & ~first & (k_inc == k_last);
                stop   = at_lsb & lrclk & ~en;
                do_pop = first | (at_lsb & ~stop);
                if (stop) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun <= 1'b0;
        end else if (do_pop & fifo_empty) begin
            underrun <= 1'b1;
        end else if (underrun_clr) begin
            underrun <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bclk     <= 1'b0;
            lrclk    <= 1'b0;
            sdata    <= 1'b0;
            div_cnt  <= '0;
            div_lat  <= '0;
            wlen_lat <= 1'b0;
            first    <= 1'b0;
            bit_k    <= '0;
            shreg    <= '0;
            nxt_word <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    bclk    <= 1'b0;
                    lrclk   <= 1'b0;
                    sdata   <= 1'b0;
                    div_cnt <= '0;
                    bit_k   <= '0;
                    first   <= en;
                    if (en) begin
                        div_lat  <= clkdiv;
                        wlen_lat <= wlen;
                    end
                end
                ST_RUN: begin
                    first <= 1'b0;
                    if (stop) begin
                        bclk    <= 1'b0;
                        lrclk   <= 1'b0;
                        sdata   <= 1'b0;
                        div_cnt <= '0;
                        bit_k   <= '0;
                    end else begin
                        // The first RUN cycle restarts the divider as if bclk
                        // had just fallen, so the low phase has full length.
                        if (first | div_tc) begin
                            div_cnt <= '0;
                            if (!first) begin
                                bclk <= ~bclk;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                        if (ev) begin
                            if (first) begin
                                bit_k <= '0;
                                lrclk <= 1'b0;
                                sdata <= pop_word[31];
                                shreg <= {pop_word[30:0], 1'b0};
                            end else if (bit_k == k_last) begin
                                // Word popped at the previous LSB event starts here.
                                bit_k <= '0;
                                sdata <= nxt_word[31];
                                shreg <= {nxt_word[30:0], 1'b0};
                            end else begin
                                bit_k <= k_inc;
                                sdata <= shreg[31];
                                shreg <= {shreg[30:0], 1'b0};
                                if (at_lsb) begin
                                    lrclk    <= ~lrclk;
                                    nxt_word <= pop_word;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cbi980_i2s_tx.sv
// Scoreboard bench for cbi980_i2s_tx: expected slot words are queued when
// samples are written; a monitor deserialises sdata on bclk rising edges and
// compares each slot as lrclk changes.
module tb_cbi980_i2s_tx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [7:0]  clkdiv = '0;
    logic        wlen = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  level;
    logic        underrun;
    logic        underrun_clr = 1'b0;
    logic        irq;
    logic        bclk;
    logic        lrclk;
    logic        sdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] word;
        int          bits;
    } exp_t;
    exp_t exp_q[$];

    // monitor state
    logic [31:0] acc = '0;
    int          nb = 0;
    logic        prev_lr = 1'b0;
    logic        bclk_q = 1'b0;
    logic        mon_clr = 1'b0;
    int          mon_done = 0;
    int          rises = 0;
    int          cyc = 0;
    int          last_rise = 0;
    int          period = 0;
    int          done_rises[$];
    int          base;

    cbi980_i2s_tx #(
        .DEPTH (8),
        .DIV_W (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .clkdiv       (clkdiv),
        .wlen         (wlen),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .level        (level),
        .underrun     (underrun),
        .underrun_clr (underrun_clr),
        .irq          (irq),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .sdata        (sdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst || mon_clr) begin
            acc = '0;
            nb = 0;
            prev_lr = 1'b0;
            bclk_q = 1'b0;
            rises = 0;
            done_rises.delete();
            if (rst) exp_q.delete();
        end else begin
            cyc++;
            if (bclk && !bclk_q) begin
                rises++;
                period = cyc - last_rise;
                last_rise = cyc;
                acc = {acc[30:0], sdata};
                nb++;
                if (lrclk != prev_lr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL sb_unexpected_word actual=0x%0h bits=%0d expected=none", acc, nb);
                    end else begin
                        e = exp_q.pop_front();
                        chk("sb_word", acc, e.word);
                        chk("sb_bits", 32'(nb), 32'(e.bits));
                    end
                    mon_done++;
                    done_rises.push_back(rises);
                    acc = '0;
                    nb = 0;
                end
                prev_lr = lrclk;
            end
            bclk_q = bclk;
        end
    end

    task automatic push_exp(input logic [31:0] w, input int bits);
        exp_t e;
        e.word = w;
        e.bits = bits;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [31:0] w);
        s_data = w;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (mon_done < target && n < 4000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (mon_done < target) begin
            failures++;
            $display("FAIL %s timeout actual=%0d expected=%0d", name, mon_done, target);
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        int quiet = 0;
        while (quiet < 8 && n < 4000) begin
            @(negedge clk);
            n++;
            quiet = bclk ? 0 : quiet + 1;
        end
        checks++;
        if (quiet < 8) begin
            failures++;
            $display("FAIL %s timeout actual=bclk_active expected=idle", name);
        end
    endtask

    task automatic mon_reset();
        @(posedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic clear_underrun();
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
    endtask

    initial begin
        // reset values and s_ready release
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_bclk", 32'(bclk), 32'd0);
        chk("rst_lrclk", 32'(lrclk), 32'd0);
        chk("rst_sdata", 32'(sdata), 32'd0);
        rst = 1'b0;
        #1;
        chk("ready_before_edge", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("ready_after_edge", 32'(s_ready), 32'd1);

        // 32-bit slots, clkdiv=1
        clkdiv = 8'd1;
        wlen = 1'b1;
        base = mon_done;
        push_exp(32'hA5A5A5A5, 32);
        push_exp(32'h12345678, 32);
        push_exp(32'h00000000, 32);
        push_word(32'hA5A5A5A5);
        push_word(32'h12345678);
        chk("t1_level_2", 32'(level), 32'd2);
        chk("t1_irq_disabled", 32'(irq), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("t1_irq_low_level", 32'(irq), 32'd1);
        wait_done(base + 2, "t1_frame");
        chk("t1_bclk_period", 32'(period), 32'd4);
        chk("t1_frame_rises", 32'(done_rises[1]), 32'd64);
        en = 1'b0;
        wait_idle("t1_idle");
        chk("t1_level_0", 32'(level), 32'd0);
        chk("t1_idle_lrclk", 32'(lrclk), 32'd0);
        chk("t1_idle_sdata", 32'(sdata), 32'd0);
        chk("t1_right_partial_bits", 32'(nb), 32'd31);
        chk("t1_right_partial_data", acc, 32'd0);
        chk("t1_underrun", 32'(underrun), 32'd1);
        chk("t1_words", 32'(mon_done - base), 32'd3);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'd0);
        mon_reset();
        clear_underrun();
        chk("t1_underrun_cleared", 32'(underrun), 32'd0);

        // 16-bit slots, clkdiv=0; settings changed mid-run must be ignored
        clkdiv = 8'd0;
        wlen = 1'b0;
        base = mon_done;
        push_exp(32'h0000FFFF, 16);
        push_exp(32'h00000001, 16);
        push_exp(32'h00000000, 16);
        push_word(32'hFFFF1234);
        push_word(32'h00018000);
        en = 1'b1;
        repeat (3) @(negedge clk);
        clkdiv = 8'd5;
        wlen = 1'b1;
        wait_done(base + 2, "t2_frame");
        chk("t2_bclk_period", 32'(period), 32'd2);
        chk("t2_frame_rises", 32'(done_rises[1]), 32'd32);
        en = 1'b0;
        wait_idle("t2_idle");
        chk("t2_right_partial_bits", 32'(nb), 32'd15);
        chk("t2_words", 32'(mon_done - base), 32'd3);
        clkdiv = 8'd0;
        wlen = 1'b0;
        mon_reset();
        clear_underrun();

        // underrun from an empty FIFO; clear vs set priority
        base = mon_done;
        push_exp(32'h00000000, 16);
        en = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t3_underrun_first", 32'(underrun), 32'd1);
        chk("t3_irq", 32'(irq), 32'd1);
        chk("t3_sdata_zero", 32'(sdata), 32'd0);
        repeat (3) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("t3_clr_no_pop", 32'(underrun), 32'd0);
        repeat (25) @(negedge clk);
        chk("t3_before_pop", 32'(underrun), 32'd0);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        chk("t3_set_beats_clr", 32'(underrun), 32'd1);
        en = 1'b0;
        wait_idle("t3_idle");
        chk("t3_words", 32'(mon_done - base), 32'd1);
        mon_reset();
        clear_underrun();

        // FIFO full boundary: 9th word held until the first pop
        base = mon_done;
        for (int i = 0; i < 8; i++) begin
            push_exp(32'(16'hC000 + 16'(i)), 16);
            push_word({16'hC000 + 16'(i), 16'hBEEF});
        end
        push_exp(32'h0000C008, 16);
        s_data = 32'hC008BEEF;
        s_valid = 1'b1;
        @(negedge clk);
        chk("t4_level_full", 32'(level), 32'd8);
        chk("t4_ready_full", 32'(s_ready), 32'd0);
        chk("t4_irq_full", 32'(irq), 32'd0);
        en = 1'b1;
        @(negedge clk);
        chk("t4_ready_no_pop_yet", 32'(s_ready), 32'd0);
        @(negedge clk);
        chk("t4_level_after_pop", 32'(level), 32'd7);
        chk("t4_ready_after_pop", 32'(s_ready), 32'd1);
        @(negedge clk);
        chk("t4_ninth_accepted", 32'(level), 32'd8);
        s_valid = 1'b0;
        wait_done(base + 8, "t4_words8");
        en = 1'b0;
        wait_idle("t4_idle");
        chk("t4_right_partial_bits", 32'(nb), 32'd15);
        chk("t4_right_partial_data", acc, 32'd0);
        chk("t4_underrun", 32'(underrun), 32'd1);
        chk("t4_words", 32'(mon_done - base), 32'd9);
        mon_reset();

        // asynchronous reset in the middle of the right slot
        clkdiv = 8'd1;
        wlen = 1'b1;
        base = mon_done;
        push_exp(32'h0F0F0F0F, 32);
        push_word(32'h0F0F0F0F);
        push_word(32'hFFFFFFFF);
        push_word(32'h11111111);
        en = 1'b1;
        wait_done(base + 1, "t5_left");
        chk("t5_pre_lrclk", 32'(lrclk), 32'd1);
        chk("t5_pre_bclk", 32'(bclk), 32'd1);
        chk("t5_pre_level", 32'(level), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_level", 32'(level), 32'd0);
        chk("t5_s_ready", 32'(s_ready), 32'd0);
        chk("t5_underrun", 32'(underrun), 32'd0);
        chk("t5_irq", 32'(irq), 32'd0);
        chk("t5_bclk", 32'(bclk), 32'd0);
        chk("t5_lrclk", 32'(lrclk), 32'd0);
        chk("t5_sdata", 32'(sdata), 32'd0);
        en = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_ready_release", 32'(s_ready), 32'd1);
        chk("t5_level_release", 32'(level), 32'd0);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cbi980_i2s_tx.md
CBI980_I2S_TX -- requirements
Module: cbi980_i2s_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 8, sample FIFO depth in words (power of 2, at least 4).
REQ-002 SHALL have parameter DIV_W, default 8, width of the clock-divider setting.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port en, input, 1 bit: transmit enable.
REQ-006 SHALL have port clkdiv, input, DIV_W bits: BCLK half-period in clk cycles, minus 1.
REQ-007 SHALL have port wlen, input, 1 bit: slot size, 0 = 16-bit slot, 1 = 32-bit slot.
REQ-008 SHALL have port s_data, input, 32 bits: audio sample, MSB-justified.
REQ-009 SHALL have port s_valid, input, 1 bit: s_data valid.
REQ-010 SHALL have port s_ready, output, 1 bit: FIFO accepts a word.
REQ-011 SHALL have port level, output, $clog2(DEPTH)+1 bits: FIFO occupancy.
REQ-012 SHALL have port underrun, output, 1 bit: sticky underrun flag.
REQ-013 SHALL have port underrun_clr, input, 1 bit: single-cycle clear of underrun.
REQ-014 SHALL have port irq, output, 1 bit: interrupt request.
REQ-015 SHALL have ports bclk, lrclk and sdata, outputs, 1 bit each: I2S bit clock, word select and serial data.

Function
REQ-016 SHALL push s_data into the FIFO when s_valid & s_ready; s_ready = ~full, evaluated before any same-cycle pop (full + pop + push -> push refused).
REQ-017 SHALL keep a word pushed into an empty FIFO in the same cycle as a pop attempt; that pop reports underrun.
REQ-018 SHALL implement FSM states IDLE and RUN; IDLE->RUN when en=1; RUN->IDLE only at the falling-edge event that drives the right-channel LSB while en=0 (graceful stop at frame boundary).
REQ-019 SHALL latch clkdiv and wlen on IDLE->RUN and ignore changes to them in RUN.
REQ-020 SHALL in IDLE hold bclk=0, lrclk=0, sdata=0, with divider and bit counters cleared.
REQ-021 SHALL in RUN toggle bclk every clkdiv+1 clk cycles; clkdiv=0 -> bclk = clk/2.
REQ-022 SHALL update sdata and lrclk only on bclk falling-edge events (the cycle bclk goes 1->0, plus the first cycle of RUN).
REQ-023 SHALL use a bit index k = 0..S-1 per channel, S = 16 or 32; at k=0 drive the word MSB, and at each subsequent event shift MSB-first.
REQ-024 SHALL at k=S-1 drive the LSB, toggle lrclk, and pop the next channel's word, so that lrclk leads the MSB by one BCLK.
REQ-025 SHALL pop the first left word and drive its MSB (lrclk=0) at the first event of RUN.
REQ-026 SHALL assign popped words alternately left then right, starting left after each IDLE->RUN.
REQ-027 SHALL transmit s_data[31:16] when S=16.
REQ-028 SHALL on a pop from an empty FIFO transmit all zeros for that channel and set underrun.
REQ-029 SHALL keep underrun set until underrun_clr; a simultaneous set and clear leaves it set.
REQ-030 SHALL drive irq = underrun | (en & level <= DEPTH/2), combinational from registers.

Reset
REQ-031 SHALL while rst=1 force FIFO empty, level=0, s_ready=0, underrun=0, irq=0, bclk=0, lrclk=0, sdata=0, FSM=IDLE, with immediate effect, including mid-frame.
REQ-032 SHALL assert s_ready=1 from the first clk edge after rst falls.

Structure
REQ-033 SHALL place the FSM state encoding and the slot-length constants (16, 32) in shared package cbi980_pkg.
REQ-034 SHALL implement the FIFO as sub-module cbi980_fifo (synchronous, single clock, level output); the divider, FSM and shifter stay in the top module.

Verification
REQ-035 SHALL verify: clkdiv=1, wlen=1, push 0xA5A5A5A5 and 0x12345678, en=1 -> bclk period 4 clk; lrclk 0 for 32 BCLK then 1 for 32 BCLK; sdata carries the words MSB-first, each MSB one BCLK after the lrclk edge; level 2->0.
REQ-036 SHALL verify: wlen=0, push 0xFFFF1234 and 0x00018000 -> left slot 0xFFFF, right slot 0x0001, frame of 32 BCLK.
REQ-037 SHALL verify: en=1 with an empty FIFO -> sdata=0, underrun=1 and irq=1 after the first event; underrun_clr pulsed on the cycle of the next empty pop -> underrun stays 1.
REQ-038 SHALL verify: en=0, push 9 words -> level=8, s_ready=0, 9th word held; en=1 -> s_ready=1 the cycle after the first pop, and the 9th word is accepted.
REQ-039 SHALL verify: en dropped during the left slot -> the right slot completes and the FSM enters IDLE at the right LSB event, with bclk, lrclk and sdata at 0 afterwards.
REQ-040 SHALL verify: rst pulsed mid-frame -> all outputs reach their reset values with no clk edge, and level=0.
